// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: one-outstanding-request memory FSM feeding a
// small prefetch queue of {instr, pc_next} entries toward decode.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   redirect_valid/pc     flush queue and restart fetch at redirect_pc
//   halt                  block new fetches; an outstanding one completes
//   imem_req/addr         read request, address held until imem_done
//   imem_done/rdata       read response
//   instr_valid/ready     head-of-queue handshake toward decode
//   instr, instr_pc_next  head instruction and its PC + PC_STEP
//   count                 queue occupancy
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response
// straight to decode in the cycle it arrives when the queue is empty.
module fetch_queue_unit #(
  parameter int PC_WIDTH = 16,
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect_valid,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  input  logic                     halt,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_done,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [PC_WIDTH-1:0]      instr_pc_next,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SQUASH
  } state_t;

  state_t state_q, state_d;

  logic [PC_WIDTH-1:0]    fetch_pc_q;
  logic [PC_WIDTH-1:0]    req_pc_q;
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pcn_mem [DEPTH];

  logic q_valid;
  logic resp_ok;
  logic fetch_start;
  logic push;
  logic pop;
  logic [PC_WIDTH-1:0] resp_pcn;

  assign q_valid = (count_q != '0);
  assign resp_pcn = req_pc_q + STEP;

  // Occupancy alone gates a new fetch: we only leave IDLE with a free
  // slot, and only one request is ever in flight, so the slot stays
  // reserved for its response.
  assign fetch_start = (state_q == IDLE) && !halt
                    && !redirect_valid && (count_q < FULL);

  // A response counts only in WAIT and only if no redirect kills it.
  assign resp_ok = (state_q == WAIT) && imem_done && !redirect_valid;

  // The head shown alongside a redirect is not consumed.
  assign pop = q_valid && instr_ready && !redirect_valid;

  assign imem_req  = (state_q != IDLE);
  // req_pc_q, not fetch_pc_q: a redirect while a request is in flight
  // moves fetch_pc, but the bus address must stay put until imem_done.
  assign imem_addr = req_pc_q;
  assign count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit    = resp_ok && !q_valid;
  assign instr_valid   = q_valid || bypass_hit;
  assign instr         = bypass_hit ? imem_rdata : instr_mem[rd_ptr_q];
  assign instr_pc_next = bypass_hit ? resp_pcn : pcn_mem[rd_ptr_q];
  assign push          = resp_ok && !(bypass_hit && instr_ready);
`else
  assign instr_valid   = q_valid;
  assign instr         = instr_mem[rd_ptr_q];
  assign instr_pc_next = pcn_mem[rd_ptr_q];
  assign push          = resp_ok;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_start) state_d = WAIT;
      end
      WAIT: begin
        if (imem_done) state_d = IDLE;
        else if (redirect_valid) state_d = SQUASH;
      end
      SQUASH: begin
        if (imem_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fetch_start) req_pc_q <= fetch_pc_q;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (resp_ok) fetch_pc_q <= fetch_pc_q + STEP;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop) count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pcn_mem[wr_ptr_q]   <= resp_pcn;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: memory responder model, scoreboard of
// expected {instr, pc_next}, table-driven runs plus corner sequences.
module tb_fetch_queue_unit;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc_next;
  logic [2:0]  count;

  fetch_queue_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_done(imem_done),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc_next(instr_pc_next),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] pcn;
  } exp_t;

  typedef struct {
    logic [15:0] start_pc;
    int          lat;
    int          gap;
    int          nfetch;
    logic [15:0] exp_last;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] addr_log[$];
  int          total = 0;
  int          bad = 0;
  int          lat = 0;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = '0;
  logic [15:0] exp_pc = '0;
  logic        stale = 1'b0;
  int          req_cnt = 0;
  int          pop_cnt = 0;
  logic [15:0] last_pcn = '0;
  logic        last_valid = 1'b0;
  logic        rdy = 1'b0;
  logic        hlt = 1'b1;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic rd, input logic [15:0] rpc);
    int   n0;
    logic byp;
    exp_t e;
    @(negedge clk);
    imem_done = 1'b0;
    if (!mem_busy && imem_req) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_addr = imem_addr;
      req_cnt++;
      addr_log.push_back(imem_addr);
      chk("fetch_addr", imem_addr, exp_pc);
    end
    if (mem_busy) begin
      chk("addr_hold", {imem_req, imem_addr}, {1'b1, mem_addr});
      if (mem_cnt == 0) begin
        imem_done  = 1'b1;
        imem_rdata = mem_data(mem_addr);
        mem_busy   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    redirect_valid = rd;
    redirect_pc    = rpc;
    halt           = hlt;
    instr_ready    = rdy;
    n0  = sb.size();
    byp = 1'b0;
    chk("count", count, n0);
    if (imem_done) begin
      if (!stale && !rd) begin
        byp = BYP && (n0 == 0);
        sb.push_back(exp_t'({imem_rdata, mem_addr + 16'd2}));
        exp_pc = mem_addr + 16'd2;
      end
      stale = 1'b0;
    end
    if (rd) begin
      stale  = mem_busy;
      exp_pc = rpc;
    end
    #1;
    last_valid = instr_valid;
    chk("instr_valid", instr_valid, (n0 != 0) || byp);
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("instr", instr, e.ins);
        chk("instr_pc_next", instr_pc_next, e.pcn);
        pop_cnt++;
        last_pcn = instr_pc_next;
      end
    end
    if (rd) sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h1234;
    imem_done      = 1'b1;
    imem_rdata     = 16'hDEAD;
    halt           = 1'b0;
    instr_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_req", imem_req, 1'b0);
    chk("reset_valid", instr_valid, 1'b0);
    chk("reset_count", count, 3'd0);
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    imem_done      = 1'b0;
    halt           = 1'b1;
    instr_ready    = 1'b0;
    sb.delete();
    addr_log.delete();
    mem_busy = 1'b0;
    stale    = 1'b0;
    exp_pc   = 16'h0000;
    req_cnt  = 0;
    pop_cnt  = 0;
    rdy      = 1'b0;
    hlt      = 1'b1;
  endtask

  task automatic until_busy();
    int i;
    for (i = 0; i < 20 && !mem_busy; i++) tick(1'b0, 16'h0);
    chk("wait_busy", mem_busy, 1'b1);
  endtask

  task automatic until_done_next();
    int i;
    for (i = 0; i < 20 && !(mem_busy && mem_cnt == 0); i++)
      tick(1'b0, 16'h0);
    chk("wait_done", mem_busy && mem_cnt == 0, 1'b1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h0000, 0, 0, 5, 16'h000A};
    vecs[1] = '{16'h0100, 1, 1, 6, 16'h010C};
    vecs[2] = '{16'hFFFC, 2, 2, 4, 16'h0004};
    vecs[3] = '{16'h0A00, 3, 0, 3, 16'h0A06};
    vecs[4] = '{16'h1230, 0, 3, 8, 16'h1240};

    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    imem_done = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;

    // in-order streaming from reset
    do_reset();
    hlt = 1'b0; rdy = 1'b1; lat = 1;
    repeat (20) tick(1'b0, 16'h0);
    chk("stream_n", addr_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("stream_addr", addr_log[i], 32'(2 * i));
    chk("stream_pops", pop_cnt >= 4, 1'b1);

    // table-driven runs: start pc, latency, ready gaps, fetch count
    foreach (vecs[v]) begin
      int cyc;
      do_reset();
      tick(1'b1, vecs[v].start_pc);
      hlt = 1'b0;
      lat = vecs[v].lat;
      pop_cnt = 0;
      for (cyc = 0; cyc < 400; cyc++) begin
        if (req_cnt >= vecs[v].nfetch && sb.size() == 0 && !mem_busy)
          break;
        hlt = (req_cnt >= vecs[v].nfetch);
        rdy = ($urandom_range(vecs[v].gap, 0) == 0);
        tick(1'b0, 16'h0);
      end
      chk("vec_timeout", cyc < 400, 1'b1);
      chk("vec_pops", pop_cnt, vecs[v].nfetch);
      chk("vec_last_pcn", last_pcn, vecs[v].exp_last);
    end

    // fill with decode stalled, then one pop frees one fetch
    do_reset();
    hlt = 1'b0; rdy = 1'b0; lat = 0;
    repeat (16) tick(1'b0, 16'h0);
    chk("full_count", count, 3'd4);
    chk("full_req", imem_req, 1'b0);
    chk("full_fetches", req_cnt, 4);
    rdy = 1'b1;
    tick(1'b0, 16'h0);
    rdy = 1'b0;
    repeat (6) tick(1'b0, 16'h0);
    chk("refill_fetches", req_cnt, 5);
    chk("refill_addr", mem_addr, 16'h0008);
    chk("refill_count", count, 3'd4);

    // redirect while waiting; response lands 3 cycles later
    do_reset();
    hlt = 1'b0; rdy = 1'b1; lat = 4;
    until_busy();
    tick(1'b1, 16'h0100);
    chk("squash_req", imem_req, 1'b1);
    chk("squash_addr", imem_addr, 16'h0000);
    for (int i = 0; i < 10 && req_cnt < 2; i++) tick(1'b0, 16'h0);
    chk("squash_refetch", req_cnt, 2);
    chk("squash_new_addr", mem_addr, 16'h0100);
    repeat (8) tick(1'b0, 16'h0);
    chk("squash_pops", pop_cnt >= 1, 1'b1);

    // redirect together with response and pop, two entries queued
    do_reset();
    hlt = 1'b0; rdy = 1'b0; lat = 0;
    for (int i = 0; i < 12 && sb.size() < 2; i++) tick(1'b0, 16'h0);
    chk("pre_count", sb.size(), 2);
    lat = 2;
    until_done_next();
    rdy = 1'b1;
    tick(1'b1, 16'h0040);
    rdy = 1'b0;
    tick(1'b0, 16'h0);
    chk("redir_count", count, 3'd0);
    chk("redir_valid", instr_valid, 1'b0);
    for (int i = 0; i < 8 && !mem_busy; i++) tick(1'b0, 16'h0);
    chk("redir_addr", mem_addr, 16'h0040);

    // halt while a request is outstanding
    do_reset();
    hlt = 1'b0; rdy = 1'b0; lat = 2;
    until_busy();
    hlt = 1'b1;
    repeat (8) tick(1'b0, 16'h0);
    chk("halt_fetches", req_cnt, 1);
    chk("halt_count", count, 3'd1);
    chk("halt_req", imem_req, 1'b0);
    hlt = 1'b0;
    repeat (4) tick(1'b0, 16'h0);
    chk("unhalt_fetches", req_cnt, 2);

    // empty-queue response: same-cycle with bypass, next cycle without
    do_reset();
    hlt = 1'b0; rdy = 1'b1; lat = 1;
    until_done_next();
    hlt = 1'b1;
    tick(1'b0, 16'h0);
    chk("byp_valid", last_valid, BYP);
    tick(1'b0, 16'h0);
    chk("byp_count", count, BYP ? 3'd0 : 3'd1);
    chk("byp_pops", pop_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 16, width of all PC/address signals.
REQ-002 The block SHALL have parameter INSTR_WIDTH, default 16, instruction word width.
REQ-003 The block SHALL have parameter DEPTH, default 4, prefetch queue entries, power of two, 2..16.
REQ-004 The block SHALL have parameter PC_STEP, default 2, PC increment per fetched instruction.
REQ-005 The block SHALL have parameter RESET_PC, default 0, fetch PC after reset.
REQ-006 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 The block SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 The block SHALL have port redirect_pc  input  PC_WIDTH  redirect target.
REQ-010 The block SHALL have port halt  input  1  stop issuing new fetches (dump).
REQ-011 The block SHALL have port imem_req  output  1  memory read request.
REQ-012 The block SHALL have port imem_addr  output  PC_WIDTH  memory read address.
REQ-013 The block SHALL have port imem_done  input  1  read data valid this cycle.
REQ-014 The block SHALL have port imem_rdata  input  INSTR_WIDTH  read data.
REQ-015 The block SHALL have port instr_valid  output  1  queue head valid.
REQ-016 The block SHALL have port instr_ready  input  1  decode accepts head.
REQ-017 The block SHALL have port instr  output  INSTR_WIDTH  head instruction.
REQ-018 The block SHALL have port instr_pc_next  output  PC_WIDTH  head PC + PC_STEP.
REQ-019 The block SHALL have port count  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-020 FSM states SHALL be IDLE, WAIT, SQUASH.
REQ-021 IDLE -> WAIT SHALL occur when rst_n=1, halt=0, redirect_valid=0, and count + (WAIT?1:0) < DEPTH; imem_req=1 and imem_addr=fetch_pc in WAIT and SQUASH only, held stable until imem_done.
REQ-022 In WAIT, imem_done=1 SHALL push {imem_rdata, fetch_pc+PC_STEP}, advance fetch_pc by PC_STEP (mod 2^PC_WIDTH), return to IDLE.
REQ-023 At most one memory request SHALL be outstanding; its slot is reserved, so the queue never overflows.
REQ-024 A pop SHALL occur when instr_valid & instr_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-025 redirect_valid SHALL, on that edge, empty the queue (count=0), load fetch_pc=redirect_pc, and from WAIT with imem_done=0 go to SQUASH; with imem_done=1 the same cycle, the data SHALL be discarded and state becomes IDLE.
REQ-026 In SQUASH, imem_done SHALL discard data and go to IDLE; a further redirect SHALL only update fetch_pc.
REQ-027 Redirect SHALL take priority over push and pop in the same cycle; the popped head is not considered consumed.
REQ-028 halt=1 SHALL block IDLE -> WAIT only; an outstanding request completes normally.
REQ-029 Queue pointers SHALL wrap modulo DEPTH; instr_valid = (count != 0).

Reset
REQ-030 On rst_n=0 at a clock edge: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, imem_req=0, instr_valid=0; an outstanding response arriving after reset SHALL be ignored by the memory-side reset.
REQ-031 Reset SHALL override redirect, halt, and imem_done.

Configuration
REQ-032 With macro FETCH_QUEUE_BYPASS_EN defined, a response arriving in WAIT while count=0 SHALL drive instr/instr_pc_next/instr_valid combinationally that cycle, and if instr_ready=1 SHALL not be written to the queue.
REQ-033 Without FETCH_QUEUE_BYPASS_EN, every response SHALL be written to the queue and is visible at the earliest one cycle after imem_done.

Verification
REQ-034 Reset, imem_done after 1 cycle, instr_ready=1 -> imem_addr 0x0000, 0x0002, 0x0004, ...; instr_pc_next 0x0002, 0x0004, ... in order.
REQ-035 instr_ready=0, DEPTH=4 -> exactly 4 fetches, count=4, imem_req stays 0; then one pop -> one new fetch at 0x0008.
REQ-036 Redirect to 0x0100 while WAIT and imem_done 3 cycles later -> state SQUASH, stale data never on instr, next imem_addr=0x0100.
REQ-037 Redirect to 0x0040 in same cycle as imem_done and pop with count=2 -> count=0, data dropped, next fetch at 0x0040.
REQ-038 halt=1 in WAIT -> current response queued, no further imem_req until halt=0.
REQ-039 FETCH_QUEUE_BYPASS_EN defined, count=0, instr_ready=1 -> instr_valid=1 in the imem_done cycle, count stays 0; undefined -> instr_valid first 1 on the next cycle.
